i2c_controller: RTL

I2C_CONTROLLER -- requirements
Module: i2c_controller

---
 rtl/i2c_pkg.sv | 5 +
 rtl/i2c_phase_gen.sv | 31 +++
 rtl/i2c_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and default target address for the I2C controller
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP} state_t;
  localparam logic [6:0] DEFAULT_ADDR = 7'h20;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: splits each SCL bit into four QTR-clock phases.
// Ports:
//   clock, reset - system clock and asynchronous active-high reset
//   en           - count while high, hold at phase 0 otherwise
//   phase        - current quarter-bit phase P0..P3
//   phase_end    - high on the last clock of each phase
module i2c_phase_gen #(
  parameter int QTR = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] phase,
  output logic       phase_end
);
  localparam int CW = $clog2(QTR);
  logic [CW-1:0] cnt;
  assign phase_end = en && cnt == CW'(QTR - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= '0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      cnt   <= phase_end ? '0 : cnt + 1'b1;
      phase <= phase + {1'b0, phase_end};
    end
  end
endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-master I2C register write / register read controller.
// Ports:
//   clock, reset        - system clock and asynchronous active-high reset
//   go                  - one-cycle start request, accepted only when idle
//   rw                  - 0 = write wr_data to reg_ptr, 1 = read reg_ptr
//   addr_override, addr - select addr instead of TGT_ADDR as target address
//   reg_ptr, wr_data    - register index and write payload
//   SDA_in              - asynchronous bus SDA level
//   SCL_out, SDA_out    - open-drain controls (0 = drive low, 1 = release)
//   busy, done, ack_err - status; done pulses once when the transaction ends
//   rd_data             - byte from the last successful read
module i2c_controller import i2c_pkg::*; #(
  parameter int         QTR      = 4,
  parameter logic [6:0] TGT_ADDR = DEFAULT_ADDR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       rw,
  input  logic       addr_override,
  input  logic [6:0] addr,
  input  logic [4:0] reg_ptr,
  input  logic [7:0] wr_data,
  input  logic       SDA_in,
  output logic       SCL_out,
  output logic       SDA_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);
  state_t state, next_state;
  logic [1:0] phase, sync, byte_idx;
  logic       phase_end, bit_end, sample, smp, rw_q;
  logic [2:0] bit_cnt;
  logic [7:0] sh, wd_q;
  logic [6:0] addr_q;
  logic [4:0] reg_q;
  assign busy    = state != IDLE;
  assign bit_end = phase_end && phase == 2'd3;
  assign sample  = phase_end && phase == 2'd2;
  i2c_phase_gen #(.QTR(QTR)) u_phase (
    .clock    (clock),
    .reset    (reset),
    .en       (busy),
    .phase    (phase),
    .phase_end(phase_end)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  // byte_idx: 0 = write address, 1 = register, 2 = write data or read address
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = go ? START : IDLE;
    else if (bit_end)
      case (state)
        START:   next_state = TX_BYTE;
        TX_BYTE: next_state = bit_cnt == 3'd7 ? RX_ACK : TX_BYTE;
        RX_ACK:  next_state = smp ? STOP :
                              byte_idx == 2'd1 ? (rw_q ? RSTART : TX_BYTE) :
                              byte_idx == 2'd2 ? (rw_q ? RX_BYTE : STOP) : TX_BYTE;
        RSTART:  next_state = TX_BYTE;
        RX_BYTE: next_state = bit_cnt == 3'd7 ? TX_NACK : RX_BYTE;
        TX_NACK: next_state = STOP;
        default: next_state = IDLE;
      endcase
  end
  // Repeated START first pulls SCL low so the target releases its ACK before SDA rises.
  always_comb begin
    SCL_out = 1'b1;
    SDA_out = 1'b1;
    case (state)
      START:                    SDA_out = !phase[1];
      TX_BYTE: begin
        SCL_out = phase[1];
        SDA_out = sh[7];
      end
      RX_ACK, RX_BYTE, TX_NACK: SCL_out = phase[1];
      RSTART: begin
        SCL_out = phase != 2'd0;
        SDA_out = !phase[1];
      end
      STOP: begin
        SCL_out = phase != 2'd0;
        SDA_out = phase[1];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync     <= 2'b11;
      smp      <= 1'b1;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= 8'h00;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      sync <= {sync[0], SDA_in};
      done <= state == STOP && bit_end;
      if (state == IDLE && go) begin
        rw_q    <= rw;
        addr_q  <= addr_override ? addr : TGT_ADDR;
        reg_q   <= reg_ptr;
        wd_q    <= wr_data;
        ack_err <= 1'b0;
      end
      if (sample) begin
        smp <= sync[1];
        if (state == RX_BYTE) sh <= {sh[6:0], sync[1]};
      end
      if (bit_end)
        case (state)
          START: begin
            sh       <= {addr_q, 1'b0};
            bit_cnt  <= '0;
            byte_idx <= '0;
          end
          TX_BYTE: begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_ACK:
            if (smp) ack_err <= 1'b1;
            else begin
              byte_idx <= byte_idx + 2'd1;
              sh       <= byte_idx == 2'd0 ? {3'b000, reg_q} : wd_q;
            end
          RSTART: sh <= {addr_q, 1'b1};
          RX_BYTE: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rd_data <= sh;
          end
          default: ;
        endcase
    end
  end
endmodule
